axil_uart_fifo: RTL and testbench



---
 rtl/axil_uart_fifo.sv | 250 +++++++++++++++++++++++++
 tb/tb_axil_uart_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_uart_fifo.sv
// rtl/axil_uart_fifo.sv - AXI-Lite 8N1 UART with TX/RX FIFOs and runtime baud divisor
// Optional interrupt output: define AXIL_UART_IRQ_EN.
module axil_uart_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  uart_tx,
  input  logic                  uart_rx
`ifdef AXIL_UART_IRQ_EN
  ,
  output logic                  irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0] bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_val;
  logic [15:0] div_q, div_wr;
  logic tx_ovf_q, rx_ovr_q, frame_err_q;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  state_e tx_state_q, rx_state_q;
  logic [15:0] tx_cnt_q, tx_div_q, rx_cnt_q, rx_div_q;
  logic [7:0] tx_sh_q, rx_sh_q;
  logic [2:0] tx_bit_q, rx_bit_q;
  logic tx_q, rx_s1_q, rx_s2_q, rx_s3_q;
  logic [31:0] ie_rd;

  wire wr_hs  = awready_q & s_axil_awvalid & s_axil_wvalid;
  wire rd_hs  = arready_q & s_axil_arvalid;
  wire wr_map = (s_axil_awaddr[ADDR_WIDTH-1:4] == '0);
  wire rd_map = (s_axil_araddr[ADDR_WIDTH-1:4] == '0);
  wire [1:0] wr_sel = s_axil_awaddr[3:2];
  wire [1:0] rd_sel = s_axil_araddr[3:2];
  wire wr_ok  = wr_hs & wr_map & s_axil_wstrb[0];
  wire st_w1c = wr_ok & (wr_sel == 2'd1);

  wire tx_empty = (tx_wp_q == tx_rp_q);
  wire tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  wire rx_empty = (rx_wp_q == rx_rp_q);
  wire rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  wire tx_busy  = (tx_state_q != S_IDLE);
  wire [7:0] rx_byte = rx_empty ? 8'h00 : rx_mem[rx_rp_q[AW-1:0]];

  wire tx_push_req = wr_ok & (wr_sel == 2'd0);
  wire tx_push     = tx_push_req & ~tx_full;
  wire tx_end      = (tx_cnt_q == tx_div_q - 16'd1);
  wire tx_pop      = ~tx_empty & ((tx_state_q == S_IDLE) | ((tx_state_q == S_STOP) & tx_end));

  wire rx_end      = (rx_cnt_q == rx_div_q - 16'd1);
  wire rx_half     = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
  wire rx_stop_smp = (rx_state_q == S_STOP) & rx_end;
  wire rx_push_req = rx_stop_smp & rx_s2_q;
  wire rx_ferr     = rx_stop_smp & ~rx_s2_q;
  wire rx_pop      = rd_hs & rd_map & (rd_sel == 2'd0) & ~rx_empty;
  wire rx_push     = rx_push_req & (~rx_full | rx_pop);
  wire rx_ovr_set  = rx_push_req & rx_full & ~rx_pop;

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0],
                       s_axil_wdata[DATA_WIDTH-1:16], s_axil_wstrb[STRB_WIDTH-1:2]};

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = awready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign uart_tx        = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= 2'b00;
      arready_q <= 1'b0; rvalid_q <= 1'b0; rresp_q <= 2'b00; rdata_q <= '0;
    end else begin
      awready_q <= s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~awready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_map ? 2'b00 : 2'b10;
      end else if (s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= s_axil_arvalid & ~rvalid_q & ~arready_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_map ? 2'b00 : 2'b10;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_map) begin
      case (rd_sel)
        2'd0:    rd_val = {23'b0, rx_empty, rx_byte};
        2'd1:    rd_val = {24'b0, tx_ovf_q, tx_busy, frame_err_q, rx_ovr_q, rx_full, rx_empty, tx_empty, tx_full};
        2'd2:    rd_val = {16'b0, div_q};
        default: rd_val = ie_rd;
      endcase
    end
  end

  // The clamp applies to the merged value so a single-byte write cannot leave DIV below 4.
  always_comb begin
    div_wr = div_q;
    if (s_axil_wstrb[0]) div_wr[7:0]  = s_axil_wdata[7:0];
    if (s_axil_wstrb[1]) div_wr[15:8] = s_axil_wdata[15:8];
    if (div_wr < 16'd4) div_wr = 16'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 16'(CLK_DIV);
      tx_ovf_q <= 1'b0; rx_ovr_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      if (wr_hs && wr_map && wr_sel == 2'd2) div_q <= div_wr;
      tx_ovf_q    <= (tx_ovf_q    & ~(st_w1c & s_axil_wdata[7])) | (tx_push_req & tx_full);
      rx_ovr_q    <= (rx_ovr_q    & ~(st_w1c & s_axil_wdata[4])) | rx_ovr_set;
      frame_err_q <= (frame_err_q & ~(st_w1c & s_axil_wdata[5])) | rx_ferr;
    end
  end

`ifdef AXIL_UART_IRQ_EN
  logic [3:0] ie_q;
  logic irq_q;
  assign ie_rd = {28'b0, ie_q};
  assign irq   = irq_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q <= 4'b0; irq_q <= 1'b0;
    end else begin
      if (wr_ok && wr_sel == 2'd3) ie_q <= s_axil_wdata[3:0];
      irq_q <= |(ie_q & {tx_ovf_q | rx_ovr_q | frame_err_q, rx_full, tx_empty, ~rx_empty});
    end
  end
`else
  assign ie_rd = 32'b0;
`endif

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= s_axil_wdata[7:0];
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  // A pop on the last STOP cycle starts the next frame directly, so frames abut.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE; tx_q <= 1'b1; tx_cnt_q <= '0;
      tx_div_q <= 16'(CLK_DIV); tx_sh_q <= '0; tx_bit_q <= '0;
    end else if (tx_pop) begin
      tx_state_q <= S_START; tx_q <= 1'b0; tx_cnt_q <= '0;
      tx_div_q <= div_q; tx_sh_q <= tx_mem[tx_rp_q[AW-1:0]];
    end else begin
      case (tx_state_q)
        S_IDLE: tx_q <= 1'b1;
        S_START:
          if (tx_end) begin
            tx_state_q <= S_DATA; tx_cnt_q <= '0; tx_bit_q <= '0; tx_q <= tx_sh_q[0];
          end else tx_cnt_q <= tx_cnt_q + 16'd1;
        S_DATA:
          if (tx_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= S_STOP; tx_q <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1; tx_sh_q <= tx_sh_q >> 1; tx_q <= tx_sh_q[1];
            end
          end else tx_cnt_q <= tx_cnt_q + 16'd1;
        S_STOP:
          if (tx_end) tx_state_q <= S_IDLE;
          else tx_cnt_q <= tx_cnt_q + 16'd1;
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_cnt_q <= '0; rx_div_q <= 16'(CLK_DIV);
      rx_sh_q <= '0; rx_bit_q <= '0;
    end else begin
      rx_s1_q <= uart_rx; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
      case (rx_state_q)
        S_IDLE:
          if (rx_s3_q && !rx_s2_q) begin
            rx_state_q <= S_START; rx_cnt_q <= '0; rx_div_q <= div_q;
          end
        S_START:
          if (rx_half) begin
            rx_cnt_q <= '0; rx_bit_q <= '0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        S_DATA:
          if (rx_end) begin
            rx_cnt_q <= '0; rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        S_STOP:
          if (rx_end) rx_state_q <= S_IDLE;
          else rx_cnt_q <= rx_cnt_q + 16'd1;
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_uart_fifo.sv
// tb/tb_axil_uart_fifo.sv - directed/randomized bench for axil_uart_fifo
// Reference expectations come from frame arithmetic and byte queues.
module tb_axil_uart_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, uart_tx, uart_rx;
  logic [1:0] bresp, rresp;
  logic loop_en = 1'b0, rx_drv = 1'b1;
  assign uart_rx = loop_en ? uart_tx : rx_drv;
`ifdef AXIL_UART_IRQ_EN
  logic irq;
`endif

  int n_cmp = 0, n_err = 0;

  axil_uart_fifo dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
`ifdef AXIL_UART_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit got = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); if (awready) got = 1; end
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    if (!got) chk("aw_handshake", 0, 1);
    got = 0; resp = 2'bxx;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk); if (bvalid) begin got = 1; resp = bresp; end
    end
    @(posedge clk); #1; bready = 0;
    if (!got) chk("b_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit got = 0;
    araddr = a; arvalid = 1; rready = 1;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); if (arready) got = 1; end
    @(posedge clk); #1; arvalid = 0;
    if (!got) chk("ar_handshake", 0, 1);
    got = 0; d = 'x; resp = 2'bxx;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk); if (rvalid) begin got = 1; d = rdata; resp = rresp; end
    end
    @(posedge clk); #1; rready = 0;
    if (!got) chk("r_timeout", 0, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    logic [1:0] r;
    axi_read(a, d, r);
  endtask

  function automatic logic [31:0] st(input bit txf, txe, rxe, rxf, ovr, fe, busy, ovf);
    return {24'b0, ovf, busy, fe, ovr, rxf, rxe, txe, txf};
  endfunction

  // Drives one 8N1 frame on uart_rx at 4 clocks per bit.
  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin rx_drv = fr[i]; cyc(4); end
    rx_drv = 1'b1;
  endtask

  // Checks 44 clocks of uart_tx from the start-bit edge against the ideal 8N1 waveform at DIV=4.
  task automatic tx_wave(input logic [7:0] b, input string tag);
    logic [43:0] obs, exp;
    int t;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) exp[i] = 1'b0;
      else if (i < 36) exp[i] = b[(i / 4) - 1];
      else exp[i] = 1'b1;
    end
    obs = '1; t = 0;
    fork
      wr(32'h0, {24'b0, b});
      begin
        @(negedge clk);
        while (uart_tx !== 1'b0 && t < 60) begin @(negedge clk); t++; end
        obs[0] = uart_tx;
        for (int i = 1; i < 44; i++) begin @(negedge clk); obs[i] = uart_tx; end
      end
    join
    @(posedge clk); #1;
    chk(tag, obs[31:0], exp[31:0]);
    chk({tag, "_tail"}, {20'b0, obs[43:32]}, {20'b0, exp[43:32]});
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic [7:0]  q[$];
  logic [7:0]  b;
  logic [15:0] v;
  int hold_bv, hold_ar;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    chk("reset_outputs", {22'b0, awready, wready, bvalid, arready, rvalid, bresp, rresp, uart_tx}, 32'h1);
    chk("reset_rdata", rdata, 32'h0);
    rst = 1'b0;
    cyc(2);
    rd(32'h4, d); chk("reset_status", d, st(0,1,1,0,0,0,0,0));
    rd(32'h8, d); chk("reset_div", d, 32'd434);

    v = 16'($urandom_range(0, 3));
    wr(32'h8, {16'b0, v}); rd(32'h8, d); chk("div_clamp", d, 32'd4);
    v = 16'($urandom_range(4, 1000));
    wr(32'h8, {16'b0, v}); rd(32'h8, d); chk("div_rand", d, {16'b0, v});
    wr(32'h8, 32'd4);
    axi_write(32'h8, 32'h0000_1234, 4'b0010, r); rd(32'h8, d); chk("div_strobe_hi", d, 32'h1204);
    wr(32'h8, 32'd4); rd(32'h8, d); chk("div_4", d, 32'd4);

    axi_write(32'hC, 32'hF, 4'hF, r); chk("ie_bresp", {30'b0, r}, 32'h0);
    rd(32'hC, d);
`ifdef AXIL_UART_IRQ_EN
    chk("ie_read", d, 32'hF);
    wr(32'hC, 32'h0);
`else
    chk("ie_read", d, 32'h0);
`endif

    tx_wave(8'h55, "tx_wave_55");
    rd(32'h4, d); chk("tx_idle_busy", d & 32'h40, 32'h0);
    tx_wave(8'($urandom), "tx_wave_rand");

    loop_en = 1'b1;
    wr(32'h0, 32'hA5); wr(32'h0, 32'h3C);
    cyc(150);
    rd(32'h0, d); chk("loop_a5", d, 32'h0A5);
    rd(32'h0, d); chk("loop_3c", d, 32'h03C);
    rd(32'h0, d); chk("loop_empty", d, 32'h100);
    rd(32'h4, d); chk("loop_rx_empty", d & 32'h4, 32'h4);

    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom); q.push_back(b); wr(32'h0, {24'b0, b});
    end
    cyc(5 * 40 + 80);
    for (int i = 0; i < 5; i++) begin
      b = q.pop_front(); rd(32'h0, d); chk("loop_rand", d, {24'b0, b});
    end

    for (int i = 0; i <= DEPTH; i++) begin
      if (q.size() < DEPTH) q.push_back(8'(i));
      wr(32'h0, i);
    end
    cyc((DEPTH + 1) * 40 + 100);
    rd(32'h4, d); chk("ovr_status", d, st(0, 1, q.size() == 0, q.size() == DEPTH, 1, 0, 0, 0));
    while (q.size() > 0) begin
      b = q.pop_front(); rd(32'h0, d); chk("ovr_data", d, {24'b0, b});
    end
    rd(32'h0, d); chk("ovr_drained", d, 32'h100);
    wr(32'h4, 32'h10); rd(32'h4, d); chk("ovr_w1c", d, st(0,1,1,0,0,0,0,0));
    loop_en = 1'b0;

    send_rx(8'h5A, 1'b0); cyc(10);
    rd(32'h4, d); chk("ferr_status", d, st(0,1,1,0,0,1,0,0));
    wr(32'h4, 32'h20); rd(32'h4, d); chk("ferr_w1c", d, st(0,1,1,0,0,0,0,0));
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom); send_rx(b, 1'b1); cyc(10);
      rd(32'h0, d); chk("rx_rand", d, {24'b0, b});
    end
    rx_drv = 1'b0; cyc(1); rx_drv = 1'b1; cyc(60);
    rd(32'h4, d); chk("rx_glitch", d, st(0,1,1,0,0,0,0,0));

    axi_read(32'h10, d, r); chk("unmapped_rresp", {30'b0, r}, 32'h2); chk("unmapped_rdata", d, 32'h0);
    axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, r); chk("unmapped_bresp", {30'b0, r}, 32'h2);
    rd(32'h8, d); chk("unmapped_div", d, 32'd4);
    rd(32'h4, d); chk("unmapped_status", d, st(0,1,1,0,0,0,0,0));

    awaddr = 32'h8; wdata = 32'd4; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    for (int t = 0; t < 20 && !awready; t++) @(negedge clk);
    @(posedge clk); #1;
    hold_bv = 0; hold_ar = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bvalid === 1'b1) hold_bv++;
      if (awready === 1'b0) hold_ar++;
    end
    chk("bhold_bvalid", hold_bv, 5);
    chk("bhold_awready", hold_ar, 5);
    @(posedge clk); #1; awvalid = 0; wvalid = 0; bready = 1;
    cyc(1); bready = 0; cyc(2);

    wr(32'h8, 32'd200);
    for (int i = 0; i < DEPTH + 2; i++) wr(32'h0, 32'hFF);
    rd(32'h4, d); chk("tx_ovf_status", d, st(1,0,1,0,0,0,1,1));
    wr(32'h4, 32'h80); rd(32'h4, d); chk("tx_ovf_w1c", d, st(1,0,1,0,0,0,1,0));

    hold_bv = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && hold_bv < 2500) begin @(negedge clk); hold_bv++; end
    chk("rst_midframe_low", {31'b0, uart_tx}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_outputs", {22'b0, awready, wready, bvalid, arready, rvalid, bresp, rresp, uart_tx}, 32'h1);
    cyc(1); rst = 1'b0; cyc(1);
    rd(32'h4, d); chk("rst_status", d, 32'h0000_0006);
    rd(32'h8, d); chk("rst_div", d, 32'd434);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
